// File: rtl/wb_regfile.sv
// Writeback stage of the 16-bit MIPS pipeline: selects the W-stage result, commits it to
// an 8-entry register file, and serves two bypassed decode read ports plus a debug port.
module wb_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_to_reg_w,
  input  logic                  reg_write_w,
  input  logic [DATA_WIDTH-1:0] alu_result_w,
  input  logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic [ADDR_WIDTH-1:0] rd_w,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_valid,
  output logic [CNT_WIDTH-1:0]  commit_count
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [CNT_WIDTH-1:0]  count_reg;
  logic [CNT_WIDTH-1:0]  count_next;

  assign wb_data  = mem_to_reg_w ? mem_data_w : alu_result_w;
  // Gating on reg_write_w keeps an unknown mem_to_reg_w on bubbles away from the state.
  assign wb_valid = reg_write_w && (rd_w != '0);

  // r0 is a constant; only r1..r(N-1) carry storage.
  assign regs_reg[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_reg[gi] <= '0;
        end else if (wb_valid && (rd_w == ADDR_WIDTH'(gi))) begin
          regs_reg[gi] <= wb_data;
        end
      end
    end
  endgenerate

  assign rs_data = (rs_addr == '0)                  ? '0      :
                   (wb_valid && (rd_w == rs_addr))  ? wb_data :
                                                      regs_reg[rs_addr];
  assign rt_data = (rt_addr == '0)                  ? '0      :
                   (wb_valid && (rd_w == rt_addr))  ? wb_data :
                                                      regs_reg[rt_addr];
  assign dbg_data = regs_reg[dbg_addr];

  always_comb begin
    count_next = count_reg;
    if (wb_valid && (count_reg != '1)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign commit_count = count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, writeback select, bypass,
// r0 protection, bubbles and commit counter saturation.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        mem_to_reg_w;
  logic        reg_write_w;
  logic [15:0] alu_result_w;
  logic [15:0] mem_data_w;
  logic [2:0]  rd_w;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic [2:0]  dbg_addr;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic [15:0] dbg_data;
  logic [15:0] wb_data;
  logic        wb_valid;
  logic [15:0] commit_count;

  int tests_run = 0;
  int tests_failed = 0;

  wb_regfile #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_to_reg_w (mem_to_reg_w),
    .reg_write_w  (reg_write_w),
    .alu_result_w (alu_result_w),
    .mem_data_w   (mem_data_w),
    .rd_w         (rd_w),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .dbg_addr     (dbg_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .dbg_data     (dbg_data),
    .wb_data      (wb_data),
    .wb_valid     (wb_valid),
    .commit_count (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one write on the low phase, commit on the next rising edge, then drop the enable.
  task automatic do_write(input logic [2:0] rd, input logic [15:0] alu,
                          input logic [15:0] mem, input logic m2r);
    @(negedge clk);
    rd_w         = rd;
    alu_result_w = alu;
    mem_data_w   = mem;
    mem_to_reg_w = m2r;
    reg_write_w  = 1'b1;
    @(posedge clk);
    #1;
    reg_write_w = 1'b0;
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    mem_to_reg_w = 1'b0;
    reg_write_w  = 1'b0;
    alu_result_w = '0;
    mem_data_w   = '0;
    rd_w         = '0;
    rs_addr      = '0;
    rt_addr      = '0;
    dbg_addr     = 3'd7;

    // Reset state
    #12;
    chk("reset_count", commit_count, 32'h0);
    chk("reset_dbg7", dbg_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Asynchronous reset in the middle of a cycle
    do_write(3'd3, 16'h1234, 16'h0000, 1'b0);
    dbg_addr = 3'd3;
    #1;
    chk("pre_reset_r3", dbg_data, 32'h1234);
    chk("pre_reset_count", commit_count, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_r3", dbg_data, 32'h0);
    chk("async_reset_count", commit_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rs_addr = 3'd3;
    #1;
    chk("post_release_rs3", rs_data, 32'h0);

    // 2. Writeback select
    @(negedge clk);
    rd_w = 3'd5; alu_result_w = 16'h00AA; mem_data_w = 16'hBEEF;
    mem_to_reg_w = 1'b1; reg_write_w = 1'b1; dbg_addr = 3'd5;
    #1;
    chk("wbsel_mem", wb_data, 32'hBEEF);
    chk("wbsel_valid", wb_valid, 32'h1);
    @(posedge clk);
    #1;
    reg_write_w = 1'b0;
    #1;
    chk("wbsel_mem_r5", dbg_data, 32'hBEEF);
    do_write(3'd5, 16'h00AA, 16'hBEEF, 1'b0);
    chk("wbsel_alu_r5", dbg_data, 32'h00AA);
    chk("wbsel_count", commit_count, 32'h2);

    // 3. Write-through bypass on both read ports
    do_write(3'd4, 16'h1111, 16'h0000, 1'b0);
    @(negedge clk);
    rd_w = 3'd4; alu_result_w = 16'h7777; mem_data_w = 16'h0BAD;
    mem_to_reg_w = 1'b0; reg_write_w = 1'b1;
    rs_addr = 3'd4; rt_addr = 3'd4; dbg_addr = 3'd4;
    #1;
    chk("bypass_rs", rs_data, 32'h7777);
    chk("bypass_rt", rt_data, 32'h7777);
    chk("bypass_dbg_old", dbg_data, 32'h1111);
    rt_addr = 3'd5;
    #1;
    chk("bypass_rt_other", rt_data, 32'h00AA);
    @(posedge clk);
    #1;
    reg_write_w = 1'b0;
    #1;
    chk("bypass_dbg_new", dbg_data, 32'h7777);
    chk("bypass_rs_array", rs_data, 32'h7777);
    chk("bypass_count", commit_count, 32'h4);

    // 4. r0 protection
    @(negedge clk);
    rd_w = 3'd0; alu_result_w = 16'hFFFF; mem_to_reg_w = 1'b0; reg_write_w = 1'b1;
    rs_addr = 3'd0; rt_addr = 3'd0; dbg_addr = 3'd0;
    #1;
    chk("r0_wb_valid", wb_valid, 32'h0);
    chk("r0_wb_data", wb_data, 32'hFFFF);
    chk("r0_rs", rs_data, 32'h0);
    chk("r0_rt", rt_data, 32'h0);
    @(posedge clk);
    #1;
    reg_write_w = 1'b0;
    #1;
    chk("r0_dbg", dbg_data, 32'h0);
    chk("r0_count", commit_count, 32'h4);

    // 5. Bubble, including an unknown select
    do_write(3'd2, 16'h2222, 16'h0000, 1'b0);
    @(negedge clk);
    rd_w = 3'd2; alu_result_w = 16'h5555; mem_data_w = 16'h5555;
    mem_to_reg_w = 1'b0; reg_write_w = 1'b0; rs_addr = 3'd2; dbg_addr = 3'd2;
    #1;
    chk("bubble_rs", rs_data, 32'h2222);
    chk("bubble_valid", wb_valid, 32'h0);
    chk("bubble_wb_data", wb_data, 32'h5555);
    mem_to_reg_w = 1'bx;
    @(posedge clk);
    #2;
    chk("bubble_r2", dbg_data, 32'h2222);
    chk("bubble_count", commit_count, 32'h5);
    mem_to_reg_w = 1'b0;

    // 6. Counter saturation from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("sat_reset_count", commit_count, 32'h0);
    rst_n = 1'b1;
    dbg_addr = 3'd1;
    for (int i = 1; i <= 65537; i++) begin
      logic [15:0] val;
      val = 16'(i) ^ 16'h3C3C;
      do_write(3'd1, val, 16'hDEAD, 1'b0);
      if (i == 1 || i == 65534 || i == 65535 || i == 65536 || i == 65537) begin
        chk("sat_r1", dbg_data, {16'h0, val});
        chk("sat_count", commit_count, (i >= 65535) ? 32'hFFFF : 32'(i));
      end
    end
    do_write(3'd0, 16'h1234, 16'h0000, 1'b0);
    chk("sat_r0_write", commit_count, 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
